// File: rtl/exc_ctrl.sv
// Exception/interrupt controller for stage M: detects events, captures CP0 commit values, drives flush and the fetch redirect.
// Optional internal timer interrupt is enabled by defining EXC_CTRL_TIMER_INT_EN.
module exc_ctrl #(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  inst_valid_m,
  input  logic [31:0]           pc_m,
  input  logic                  bd_m,
  input  logic [31:0]           bad_vaddr_m,
  input  logic                  instadel,
  input  logic                  adel,
  input  logic                  ades,
  input  logic                  syscall,
  input  logic                  brk,
  input  logic                  eret,
  input  logic                  ri,
  input  logic                  ov,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [31:0]           cp0_epc,
  input  logic                  cp0_we_w,
  input  logic [4:0]            cp0_waddr_w,
  input  logic [31:0]           cp0_wdata_w,
  input  logic                  redirect_ready,
  output logic                  flush,
  output logic                  exc_commit,
  output logic [4:0]            exc_code,
  output logic [31:0]           exc_epc,
  output logic                  exc_bd,
  output logic [31:0]           exc_badvaddr,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  stall_req
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_REDIRECT = 1'b1;
  localparam logic [4:0] CODE_ERET  = 5'h1e;

  logic [0:0]            state;
  logic [NUM_HW_INT-1:0] sync1, sync2;
  logic [5:0]            hw6;
  logic [31:0]           status_eff, cause_eff, epc_eff;
  logic [7:0]            ip;
  logic                  timer_ip;
  logic                  int_taken, evt;
  logic [4:0]            code;

  // Bypass a same-cycle writeback so a just-written CP0 value takes effect immediately.
  assign status_eff = (cp0_we_w && cp0_waddr_w == 5'd12) ? cp0_wdata_w : cp0_status;
  assign cause_eff  = (cp0_we_w && cp0_waddr_w == 5'd13) ? cp0_wdata_w : cp0_cause;
  assign epc_eff    = (cp0_we_w && cp0_waddr_w == 5'd14) ? cp0_wdata_w : cp0_epc;

  always_comb begin
    hw6 = '0;
    hw6[NUM_HW_INT-1:0] = sync2;
  end

  // Timer shares IP7 with the top hardware line, as on MIPS32.
  assign ip        = {hw6[5] | timer_ip, hw6[4:0], cause_eff[9:8]};
  assign int_taken = |(ip & status_eff[15:8]) && !status_eff[1] && status_eff[0] && inst_valid_m;

  logic unused_bits;
  assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:10], cause_eff[7:0]};

  always_comb begin
    evt  = 1'b0;
    code = 5'h00;
    if (state == S_IDLE && inst_valid_m) begin
      evt = 1'b1;
      if      (int_taken) code = 5'h00;
      else if (instadel)  code = 5'h04;
      else if (adel)      code = 5'h04;
      else if (ades)      code = 5'h05;
      else if (syscall)   code = 5'h08;
      else if (brk)       code = 5'h09;
      else if (ri)        code = 5'h0a;
      else if (ov)        code = 5'h0c;
      else if (eret)      code = CODE_ERET;
      else                evt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= hw_int;
      sync2 <= sync1;
    end
  end

`ifdef EXC_CTRL_TIMER_INT_EN
  logic [31:0] count, compare;
  logic        tick;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick     <= 1'b0;
      count    <= '0;
      compare  <= '0;
      timer_ip <= 1'b0;
    end else begin
      tick <= ~tick;
      if (tick) count <= count + 32'd1;
      if (cp0_we_w && cp0_waddr_w == 5'd11) begin
        compare  <= cp0_wdata_w;
        timer_ip <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        timer_ip <= 1'b1;
      end
    end
  end
`else
  assign timer_ip = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      flush          <= 1'b0;
      exc_commit     <= 1'b0;
      exc_code       <= '0;
      exc_epc        <= '0;
      exc_bd         <= 1'b0;
      exc_badvaddr   <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      flush      <= 1'b0;
      exc_commit <= 1'b0;
      case (state)
        S_IDLE: if (evt) begin
          state          <= S_REDIRECT;
          flush          <= 1'b1;
          exc_commit     <= (code != CODE_ERET);
          exc_code       <= code;
          exc_epc        <= bd_m ? pc_m - 32'd4 : pc_m;
          exc_bd         <= bd_m;
          redirect_valid <= 1'b1;
          redirect_pc    <= (code == CODE_ERET) ? epc_eff : EXC_VECTOR;
          if (!int_taken && instadel)            exc_badvaddr <= pc_m;
          else if (!int_taken && (adel || ades)) exc_badvaddr <= bad_vaddr_m;
        end
        default: if (redirect_ready) begin
          state          <= S_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  assign stall_req = redirect_valid;

endmodule
